// File: rtl/alu_md_if.sv
// Request/result bundle between decode and the ALU/multiply-divide controller.
interface alu_md_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_option;
  logic [2:0]      func_3_bits;
  logic [6:0]      func_7_bits;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_operation;
  logic            md_valid;
  logic [XLEN-1:0] md_result;
  logic            busy;

  modport master (
    output flush, in_valid, alu_option, func_3_bits, func_7_bits,
           operand_a, operand_b, out_ready,
    input  in_ready, out_valid, alu_operation, md_valid, md_result, busy
  );

  modport slave (
    input  flush, in_valid, alu_option, func_3_bits, func_7_bits,
           operand_a, operand_b, out_ready,
    output in_ready, out_valid, alu_operation, md_valid, md_result, busy
  );
endinterface

// File: rtl/alu_md_controller.sv
// Registered ALU op decoder with an iterative radix-2 RV32M/RV64M multiply/divide sequencer.
// state | meaning
// IDLE  | decode accepts; non-M ops complete in one edge
// CALC  | one shift-add / restoring-divide step per cycle, XLEN steps
// DONE  | sign fix-up and result load
module alu_md_controller #(
  parameter int XLEN = 32
) (
  input  logic   CLK,
  input  logic   RST_n,
  alu_md_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_UHE = 4'b0111,
                         OP_SHE = 4'b1000, OP_ULT = 4'b1001, OP_SLT = 4'b1010,
                         OP_SLL = 4'b1101, OP_SRL = 4'b1110, OP_SRA = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q, neg_r_q, div_zero_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q;

  logic            accept, is_m;
  logic [3:0]      dec_op;
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   rem_sh, dvs, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot, remv, res_d;

  function automatic logic [3:0] imm_op(input logic [2:0] f3, input logic f7_5);
    case (f3)
      3'b000:  imm_op = OP_ADD;
      3'b001:  imm_op = OP_SLL;
      3'b010:  imm_op = OP_SLT;
      3'b011:  imm_op = OP_ULT;
      3'b100:  imm_op = OP_XOR;
      3'b101:  imm_op = f7_5 ? OP_SRA : OP_SRL;
      3'b110:  imm_op = OP_OR;
      default: imm_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    dec_op = OP_ADD;
    is_m   = 1'b0;
    case (bus.alu_option)
      4'b0010: dec_op = imm_op(bus.func_3_bits, bus.func_7_bits[5]);
      4'b0110: begin
        if (bus.func_7_bits == 7'b0000001) is_m = 1'b1;
        else if (bus.func_3_bits == 3'b000 && bus.func_7_bits[5]) dec_op = OP_SUB;
        else dec_op = imm_op(bus.func_3_bits, bus.func_7_bits[5]);
      end
      4'b1100: begin
        case (bus.func_3_bits)
          3'b000:  dec_op = OP_SUB;
          3'b001:  dec_op = OP_XOR;
          3'b100:  dec_op = OP_SLT;
          3'b101:  dec_op = OP_SHE;
          3'b110:  dec_op = OP_ULT;
          3'b111:  dec_op = OP_UHE;
          default: dec_op = OP_ADD;
        endcase
      end
      default: dec_op = OP_ADD;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE) && (!bus.out_valid || bus.out_ready);
  assign bus.busy     = (state_q != IDLE);
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // MUL/MULH signed x signed, MULHSU signed x unsigned; DIV/REM signed on both.
  assign is_div = bus.func_3_bits[2];
  assign a_sgn  = is_div ? !bus.func_3_bits[0] : (bus.func_3_bits != 3'b011);
  assign b_sgn  = is_div ? !bus.func_3_bits[0] : !bus.func_3_bits[1];
  assign a_neg  = a_sgn && bus.operand_a[XLEN-1];
  assign b_neg  = b_sgn && bus.operand_b[XLEN-1];
  assign a_mag  = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag  = b_neg ? -bus.operand_b : bus.operand_b;

  assign rem_sh = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
  assign dvs    = {1'b0, mcand_q[XLEN-1:0]};
  assign diff   = rem_sh - dvs;

  // Divide-by-zero remainder falls out naturally: magnitude of dividend re-signed.
  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = div_zero_q ? {XLEN{1'b1}} : (neg_q ? -mplier_q : mplier_q);
  assign remv = neg_r_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign res_d = f3_q[2] ? (f3_q[1] ? remv : quot)
                         : ((f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_m) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      bus.out_valid     <= 1'b0;
      bus.md_valid      <= 1'b0;
      bus.md_result     <= '0;
      bus.alu_operation <= OP_ADD;
      cnt_q      <= '0;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.md_valid  <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (accept && !is_m) begin
        bus.alu_operation <= dec_op;
        bus.md_valid      <= 1'b0;
        bus.out_valid     <= 1'b1;
      end
      if (accept && is_m) begin
        f3_q       <= bus.func_3_bits;
        cnt_q      <= '0;
        acc_q      <= '0;
        div_zero_q <= is_div && (bus.operand_b == '0);
        neg_r_q    <= a_neg;
        if (is_div) begin
          neg_q    <= (a_neg ^ b_neg) && (bus.operand_b != '0);
          mcand_q  <= {{XLEN{1'b0}}, b_mag};
          mplier_q <= a_mag;
        end else begin
          neg_q    <= a_neg ^ b_neg;
          mcand_q  <= {{XLEN{1'b0}}, a_mag};
          mplier_q <= b_mag;
        end
      end
      if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
        if (f3_q[2]) begin
          if (rem_sh >= dvs) begin
            acc_q    <= {{(XLEN-1){1'b0}}, diff};
            mplier_q <= {mplier_q[XLEN-2:0], 1'b1};
          end else begin
            acc_q    <= {{(XLEN-1){1'b0}}, rem_sh};
            mplier_q <= {mplier_q[XLEN-2:0], 1'b0};
          end
        end else begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
        end
      end
      if (state_q == DONE) begin
        bus.md_result     <= res_d;
        bus.md_valid      <= 1'b1;
        bus.out_valid     <= 1'b1;
        bus.alu_operation <= OP_ADD;
      end
    end
  end
endmodule

// File: tb/tb_alu_md_controller.sv
// Directed bench for alu_md_controller: decode, M ops, special cases, backpressure, flush.
module tb_alu_md_controller;
  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_md_if #(.XLEN(32)) bus ();

  alu_md_controller #(.XLEN(32)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] opt, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.alu_option  = opt;
    bus.func_3_bits = f3;
    bus.func_7_bits = f7;
    bus.operand_a   = a;
    bus.operand_b   = b;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= 100) chk("issue_timeout", 64'(n), 64'd0);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = 1;
    while (!bus.out_valid && edges < 200) begin
      @(posedge CLK); #1; edges++;
    end
  endtask

  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int e;
    issue(4'b0110, f3, 7'b0000001, a, b);
    wait_out(e);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_mdv"}, 64'(bus.md_valid), 64'd1);
    chk(tag, 64'(bus.md_result), 64'(exp));
    chk({tag, "_lat"}, 64'(e), 64'd34);
    @(posedge CLK); #1;
  endtask

  initial begin
    bit seen;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_option = 4'b0010;
    bus.func_3_bits = 3'b101;
    bus.func_7_bits = 7'b0100000;
    bus.operand_a = '0;
    bus.operand_b = '0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_md_valid", 64'(bus.md_valid), 64'd0);
    chk("rst_md_result", 64'(bus.md_result), 64'd0);
    chk("rst_alu_op", 64'(bus.alu_operation), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    RST_n = 1'b1;
    @(posedge CLK); #1;
    chk("first_accept_valid", 64'(bus.out_valid), 64'd1);
    chk("sra_imm", 64'(bus.alu_operation), 64'hF);
    bus.in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("drain", 64'(bus.out_valid), 64'd0);

    issue(4'b0010, 3'b101, 7'b0000000, 0, 0);
    chk("srl_imm", 64'(bus.alu_operation), 64'hE);
    issue(4'b0110, 3'b000, 7'b0100000, 0, 0);
    chk("sub_op", 64'(bus.alu_operation), 64'h1);
    chk("sub_md_valid", 64'(bus.md_valid), 64'd0);
    issue(4'b1100, 3'b100, 7'b0000000, 0, 0);
    chk("blt", 64'(bus.alu_operation), 64'hA);
    issue(4'b1100, 3'b111, 7'b0000000, 0, 0);
    chk("bgeu", 64'(bus.alu_operation), 64'h7);
    issue(4'b0000, 3'b101, 7'b0100000, 0, 0);
    chk("other_opt_add", 64'(bus.alu_operation), 64'h0);
    issue(4'b0110, 3'b011, 7'b0000000, 0, 0);
    chk("sltu_op", 64'(bus.alu_operation), 64'h9);
    @(posedge CLK); #1;

    run_m("mul", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
    run_m("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_m("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    run_m("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run_m("div_zero", 3'b100, 32'h64, 32'd0, 32'hFFFFFFFF);
    run_m("rem_zero", 3'b110, 32'h64, 32'd0, 32'h64);
    run_m("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_m("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_m("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_m("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_m("divu", 3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC);
    run_m("remu", 3'b111, 32'd100, 32'd7, 32'd2);

    bus.out_ready = 1'b0;
    issue(4'b0010, 3'b100, 7'b0000000, 0, 0);
    chk("bp_xor", 64'(bus.alu_operation), 64'h4);
    chk("bp_md_valid", 64'(bus.md_valid), 64'd0);
    bus.alu_option = 4'b0010;
    bus.func_3_bits = 3'b110;
    bus.func_7_bits = 7'b0000000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_op", 64'(bus.alu_operation), 64'h4);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge CLK); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    chk("bp_new_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_new_op", 64'(bus.alu_operation), 64'h3);
    @(posedge CLK); #1;

    issue(4'b0110, 3'b100, 7'b0000001, 32'd1000, 32'd3);
    repeat (10) @(posedge CLK);
    #1;
    chk("flush_pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge CLK); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge CLK); #1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    issue(4'b0110, 3'b000, 7'b0000000, 32'd5, 32'd6);
    chk("post_flush_valid", 64'(bus.out_valid), 64'd1);
    chk("post_flush_add", 64'(bus.alu_operation), 64'h0);
    chk("post_flush_mdv", 64'(bus.md_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_md_controller.md
Name: alu_md_controller

Overview:
- Registered, handshaked successor to the combinational ALU operation decoder.
- Decodes the main-control ALU option plus func3/func7 into the 4-bit ALU operation code.
- Adds an iterative RV32M/RV64M multiply/divide sequencer of width XLEN. Its result is muxed into execute when md_valid is high.
- Sits between instruction decode and the execute stage. The pipeline stalls on in_ready low.

Parameters:
- XLEN, 32, operand/result width; legal range >= 4.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridable).

Ports:
- CLK  in  1  rising-edge clock
- RST_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; dominates all other inputs
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- alu_option  in  4  instruction class from main control
- func_3_bits  in  3  instruction func3
- func_7_bits  in  7  instruction func7
- operand_a  in  XLEN  rs1 value (M ops only)
- operand_b  in  XLEN  rs2 value (M ops only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts on out_valid && out_ready
- alu_operation  out  4  registered ALU code
- md_valid  out  1  1 means md_result is the writeback value
- md_result  out  XLEN  multiply/divide result
- busy  out  1  state != IDLE

Behaviour:
- ALU codes:
  - ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100
  - U_HIGH_EQ=0111, S_HIGH_EQ=1000, U_LOWER=1001, S_LOWER=1010
  - SHIFT_LEFT=1101, SHIFT_RIGHT_LOGIC=1110, SHIFT_RIGHT_ARIT=1111
- Decode for option 0010 (OP-IMM):
  - func3 000/001/010/011/100/110/111 map to ADD/SLL/S_LOWER/U_LOWER/XOR/OR/AND.
  - func3 101 maps to SRL when func7[5]=0, SRA when func7[5]=1.
- Decode for option 0110 (OP):
  - func7 = 0000001 is an M op.
  - Otherwise decode as OP-IMM, except func3 000 with func7[5]=1 is SUB.
- Decode for option 1100 (branch):
  - func3 000/001/100/101/110/111 map to SUB/XOR/S_LOWER/S_HIGH_EQ/U_LOWER/U_HIGH_EQ.
- Every other option or func combination decodes to ADD. The decoder never leaves alu_operation undriven.
- Reset (RST_n low, async):
  - State IDLE; out_valid=0, md_valid=0, md_result=0, alu_operation=0000, busy=0.
  - Counter and internal accumulators are 0.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output registers hold stable while out_valid && !out_ready.
  - out_valid clears on an accept unless a new result loads in the same cycle.
- FSM IDLE/CALC/DONE:
  - IDLE, non-M accept: next edge loads alu_operation, sets md_valid=0 and out_valid=1; state stays IDLE. Latency 1; back-to-back throughput 1/cycle.
  - IDLE, M accept: latch func3, operand magnitudes and sign flags; counter=0; go to CALC.
  - CALC: one radix-2 step per cycle, exactly XLEN cycles; after step XLEN-1, go to DONE.
  - DONE: apply sign fix-up, load md_result, set md_valid=1, out_valid=1, alu_operation=ADD; go to IDLE.
  - Total M latency is XLEN+2 edges from accept to out_valid, fixed for all operands including the special cases below.
- Multiply:
  - Shift-add on magnitudes into a 2*XLEN product, negated when the operand signs differ.
  - Signedness: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes (DIV/REM signed; DIVU/REMU unsigned).
  - Quotient is negated when the signs differ; remainder takes the dividend's sign.
- Divide by zero (detected at accept): quotient = all ones, remainder = dividend.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- flush:
  - Next edge: state IDLE, out_valid=0, md_valid=0. Any pending or in-flight result is discarded.
  - Requests presented in a flush cycle are not accepted.
- Reset mid-CALC: immediate return to reset values; no result is produced.

Test Plan:
- Reset with in_valid=1 -> all outputs 0, alu_operation=0000; first accept occurs only after RST_n deasserts.
- Option 0010, func3=101, func7=0100000 -> alu_operation=1111 one edge later; same with func7=0 -> 1110; option 0110, func3=000, func7=0100000 -> 0001.
- XLEN=32 MUL: a=FFFFFFFD, b=7 -> md_result=FFFFFFEB, md_valid=1, exactly 34 edges after accept; MULHU a=b=FFFFFFFF -> FFFFFFFE; MULHSU a=FFFFFFFF, b=2 -> FFFFFFFF.
- DIV a=0x64, b=0 -> FFFFFFFF; REM a=0x64, b=0 -> 0x64; DIV 80000000/FFFFFFFF -> 80000000; REM of the same -> 0; REM a=-7, b=2 -> FFFFFFFF.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_valid and data held, in_ready=0; raise out_ready with in_valid=1 -> new request accepted the same cycle.
- Assert flush in CALC at iteration 10 -> out_valid stays 0, busy drops next edge, in_ready=1; a following ADD request completes normally in 1 cycle.
